// File: rtl/progmem_loader_pkg.sv
// Shared types for the program-RAM bulk loader: FSM state encoding and the
// status bit positions the visor status register maps onto.
package progmem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LO    = 2'd1,
    ST_HI    = 2'd2,
    ST_WRITE = 2'd3
  } loader_state_e;

  localparam int LOADER_STATUS_BUSY  = 0;
  localparam int LOADER_STATUS_DONE  = 1;
  localparam int LOADER_STATUS_ERROR = 2;
  localparam int LOADER_STATUS_W     = 3;

endpackage

// File: rtl/progmem_loader_if.sv
// Visor/UART-facing bus of the loader plus its RAM port A outputs.
// rx_valid is a one-cycle strobe with no back-pressure: the loader has no
// ready, so a byte offered when the FSM cannot take it is either ignored
// (IDLE) or flagged as an overrun (WRITE).
interface progmem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  import progmem_loader_pkg::*;

  logic                   start;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic [ADDR_WIDTH:0]    word_count;
  logic                   abort;
  logic [7:0]             rx_data;
  logic                   rx_valid;

  logic                   busy;
  logic                   done;
  logic                   error;
  logic [ADDR_WIDTH-1:0]  ram_addr;
  logic [15:0]            ram_data;
  logic                   ram_wren;
  logic [ADDR_WIDTH:0]    words_written;
  logic [15:0]            checksum;
  logic [LOADER_STATUS_W-1:0] status;
  loader_state_e          state;

  modport master (
    output start, base_addr, word_count, abort, rx_data, rx_valid,
    input  busy, done, error, ram_addr, ram_data, ram_wren,
           words_written, checksum, status, state
  );

  modport slave (
    input  start, base_addr, word_count, abort, rx_data, rx_valid,
    output busy, done, error, ram_addr, ram_data, ram_wren,
           words_written, checksum, status, state
  );
endinterface

// File: rtl/progmem_loader_timeout.sv
// Inter-byte watchdog: reloads while idle or cleared, counts down while
// running, and flags expiry on the last counted cycle. TIMEOUT_CYCLES=0 disables.
module progmem_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expire
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT_CYCLES);
  localparam logic          ENABLED  = (TIMEOUT_CYCLES > 0);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= LOAD_VAL;
    end else if (i_clear || !i_run) begin
      r_count <= LOAD_VAL;
    end else if (r_count != '0) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign o_expire = ENABLED && i_run && !i_clear && (r_count == TW'(1));
endmodule

// File: rtl/progmem_loader.sv
// Bulk loader: packs little-endian UART bytes into 16-bit words and writes
// them to M9K port A at sequential, wrapping addresses with a running checksum.
module progmem_loader
  import progmem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              sysclk,
  input  logic              sysreset,
  progmem_loader_if.slave   bus
);
  localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH + 1)'(1);

  loader_state_e          r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [ADDR_WIDTH:0]    r_remaining;
  logic [7:0]             r_lo;
  logic                   r_done;
  logic                   r_error;
  logic [ADDR_WIDTH-1:0]  r_ram_addr;
  logic [15:0]            r_ram_data;
  logic                   r_wren;
  logic [ADDR_WIDTH:0]    r_words;
  logic [15:0]            r_checksum;

  logic w_run;
  logic w_expire;

  assign w_run = (r_state == ST_LO) || (r_state == ST_HI);

  progmem_loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) loader_timeout (
    .clk      (sysclk),
    .rst      (sysreset),
    .i_run    (w_run),
    .i_clear  (bus.rx_valid),
    .o_expire (w_expire)
  );

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_lo        <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
      r_wren      <= 1'b0;
      r_words     <= '0;
      r_checksum  <= '0;
    end else begin
      r_wren <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // abort in the same cycle suppresses a start
          if (bus.start && !bus.abort) begin
            r_addr      <= bus.base_addr;
            r_remaining <= bus.word_count;
            r_done      <= (bus.word_count == '0);
            r_error     <= 1'b0;
            r_words     <= '0;
            r_checksum  <= '0;
            r_state     <= (bus.word_count == '0) ? ST_IDLE : ST_LO;
          end
        end
        ST_LO: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
          end else if (w_expire) begin
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end else if (bus.rx_valid) begin
            r_lo    <= bus.rx_data;
            r_state <= ST_HI;
          end
        end
        ST_HI: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
          end else if (w_expire) begin
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end else if (bus.rx_valid) begin
            r_ram_addr <= r_addr;
            r_ram_data <= {bus.rx_data, r_lo};
            r_wren     <= 1'b1;
            r_state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // the word on port A commits regardless of abort or overrun
          r_checksum  <= r_checksum + r_ram_data;
          r_words     <= r_words + REM_ONE;
          r_addr      <= r_addr + ADDR_WIDTH'(1);
          r_remaining <= r_remaining - REM_ONE;
          if (bus.abort) begin
            r_state <= ST_IDLE;
          end else if (bus.rx_valid) begin
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end else if (r_remaining == REM_ONE) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_LO;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.done          = r_done;
  assign bus.error         = r_error;
  assign bus.ram_addr      = r_ram_addr;
  assign bus.ram_data      = r_ram_data;
  assign bus.ram_wren      = r_wren;
  assign bus.words_written = r_words;
  assign bus.checksum      = r_checksum;
  assign bus.state         = r_state;

  always_comb begin
    bus.status = '0;
    bus.status[LOADER_STATUS_BUSY]  = (r_state != ST_IDLE);
    bus.status[LOADER_STATUS_DONE]  = r_done;
    bus.status[LOADER_STATUS_ERROR] = r_error;
  end
endmodule

// File: tb/tb_progmem_loader.sv
// Directed bench for progmem_loader: RAM writes checked through an expected
// queue by a negedge monitor, status checked inline after each scenario.
module tb_progmem_loader;
  import progmem_loader_pkg::*;

  localparam int AW = 10;
  localparam int TO = 16;

  logic sysclk = 1'b0;
  logic sysreset = 1'b1;

  always #5 sysclk = ~sysclk;

  progmem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  progmem_loader #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sysclk   (sysclk),
    .sysreset (sysreset),
    .bus      (bus)
  );

  logic [AW+15:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int wr_before;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic start_load(input logic [AW-1:0] base, input logic [AW:0] count);
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.word_count = count;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_status(input string name, input logic b, input logic d, input logic e,
                              input logic [AW:0] words, input logic [15:0] cs);
    check({name, ".busy"}, 32'(bus.busy), 32'(b));
    check({name, ".done"}, 32'(bus.done), 32'(d));
    check({name, ".error"}, 32'(bus.error), 32'(e));
    check({name, ".words"}, 32'(bus.words_written), 32'(words));
    check({name, ".checksum"}, 32'(bus.checksum), 32'(cs));
  endtask

  // monitor: every port-A write must match the head of the expected queue
  always @(negedge sysclk) begin
    if (bus.ram_wren) begin
      logic [AW+15:0] e;
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h expected=none", bus.ram_addr, bus.ram_data);
      end else begin
        e = exp_q.pop_front();
        check("ram_write", 32'({bus.ram_addr, bus.ram_data}), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.word_count = '0;
    bus.abort = 1'b0;
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    check_status("reset", 1'b0, 1'b0, 1'b0, '0, '0);
    check("reset.ram_addr", 32'(bus.ram_addr), 0);
    check("reset.ram_data", 32'(bus.ram_data), 0);
    check("reset.ram_wren", 32'(bus.ram_wren), 0);
    sysreset = 1'b0;
    tick();

    // two words at 0x010
    expect_write(10'h010, 16'h1234);
    expect_write(10'h011, 16'h5678);
    start_load(10'h010, 11'd2);
    check("t1.busy_after_start", 32'(bus.busy), 1);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h78);
    send_byte(8'h56);
    check_status("t1", 1'b0, 1'b1, 1'b0, 11'd2, 16'h68AC);
    check("t1.status", 32'(bus.status), 32'h2);
    check("t1.hold_addr", 32'(bus.ram_addr), 32'h011);
    check("t1.hold_data", 32'(bus.ram_data), 32'h5678);
    check("t1.wren_low", 32'(bus.ram_wren), 0);

    // address wrap at the top of the RAM
    expect_write(10'h3FF, 16'h0001);
    expect_write(10'h000, 16'h0002);
    start_load(10'h3FF, 11'd2);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    check_status("t2", 1'b0, 1'b1, 1'b0, 11'd2, 16'h0003);

    // timeout after a single byte
    wr_before = wr_count;
    start_load(10'h100, 11'd1);
    bus.rx_data = 8'hAA;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    repeat (15) tick();
    check("t4.error_before", 32'(bus.error), 0);
    check("t4.busy_before", 32'(bus.busy), 1);
    tick();
    check_status("t4", 1'b0, 1'b0, 1'b1, '0, '0);
    check("t4.no_write", 32'(wr_count - wr_before), 0);

    // zero-length load completes one cycle after start
    wr_before = wr_count;
    start_load(10'h055, 11'd0);
    check_status("t3", 1'b0, 1'b1, 1'b0, '0, '0);
    tick();
    tick();
    check("t3.no_write", 32'(wr_count - wr_before), 0);

    // abort after the first of two words; start while busy is ignored
    expect_write(10'h020, 16'hBEEF);
    start_load(10'h020, 11'd2);
    send_byte(8'hEF);
    send_byte(8'hBE);
    start_load(10'h300, 11'd5);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_status("t5", 1'b0, 1'b0, 1'b0, 11'd1, 16'hBEEF);
    expect_write(10'h030, 16'h2211);
    start_load(10'h030, 11'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    check_status("t5b", 1'b0, 1'b1, 1'b0, 11'd1, 16'h2211);

    // overrun: second byte of a word followed immediately by another strobe
    wr_before = wr_count;
    expect_write(10'h040, 16'hABCD);
    start_load(10'h040, 11'd2);
    send_byte(8'hCD);
    bus.rx_data = 8'hAB;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_data = 8'h99;
    tick();
    bus.rx_valid = 1'b0;
    tick();
    tick();
    check_status("t6", 1'b0, 1'b0, 1'b1, 11'd1, 16'hABCD);
    check("t6.one_pulse", 32'(wr_count - wr_before), 1);

    tick();
    check("queue_empty", 32'(exp_q.size()), 0);
    check("total_writes", 32'(wr_count), 7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/progmem_loader.md
Name: progmem_loader

Overview:
- Bulk-load sequencer for the target MCU's dual-ported M9K program RAM.
- Assembles bytes from the debugger UART receiver into 16-bit words and drives RAM port A write cycles at sequential addresses.
- Keeps a running checksum and enforces an inter-byte timeout.
- Sits in the supervised Synapse316 wrapper, muxed onto port A ahead of the visor's single-word M9K_ADDR/M9K_DATA path. The visor starts a load, then polls busy/done/error and checksum.

Parameters:
ADDR_WIDTH, 10, RAM port A address width; addresses wrap modulo 2^ADDR_WIDTH
TIMEOUT_CYCLES, 65535, max sysclk cycles allowed between rx bytes mid-transfer; 0 disables timeout

Ports:
sysclk  in  1  system clock
sysreset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; latches base_addr/word_count and begins a load
base_addr  in  ADDR_WIDTH  first RAM word address
word_count  in  ADDR_WIDTH+1  words to load, 0..2^ADDR_WIDTH
abort  in  1  one-cycle pulse; cancels a load in progress
rx_data  in  8  received byte, already in sysclk domain
rx_valid  in  1  one-cycle strobe, rx_data valid
busy  out  1  load in progress
done  out  1  sticky; load completed normally
error  out  1  sticky; timeout or overrun
ram_addr  out  ADDR_WIDTH  port A address
ram_data  out  16  port A write data
ram_wren  out  1  port A write enable, one cycle per word
words_written  out  ADDR_WIDTH+1  words committed since start
checksum  out  16  sum mod 2^16 of committed words

Behaviour:
- Reset values: all outputs 0; state IDLE.
- States: IDLE, LO, HI, WRITE.
- IDLE + start:
  - latch base_addr into the address counter and word_count into the remaining counter;
  - clear done, error, words_written, checksum;
  - go to LO, or go to IDLE with done=1 next cycle if word_count==0.
- start while busy: ignored.
- LO + rx_valid: low byte <= rx_data; go to HI. Little-endian, low byte first.
- HI + rx_valid: high byte <= rx_data; go to WRITE.
- WRITE lasts exactly one cycle. During it:
  - ram_wren=1; ram_addr = address counter; ram_data = {hi, lo};
  - on exit, checksum += word, words_written++, address counter increments (wrapping 2^ADDR_WIDTH-1 -> 0), remaining--.
  - Next state is LO, or IDLE with done=1 if remaining hits 0.
- Latency: ram_wren asserts the cycle after the strobe carrying the high byte.
- ram_addr/ram_data are held stable outside WRITE; ram_wren=0 outside WRITE.
- Overrun: rx_valid during WRITE -> error=1; state IDLE next cycle; that byte is dropped; the current word is still written.
- Timeout (TIMEOUT_CYCLES>0):
  - a cycle counter runs in LO/HI and clears on each rx_valid;
  - reaching TIMEOUT_CYCLES -> error=1; state IDLE.
  - The LO-state wait before the first byte is also timed.
- abort in LO/HI/WRITE:
  - state IDLE next cycle; done and error unchanged (both 0);
  - a write already in WRITE completes.
- abort and start in the same cycle: abort wins; no start while busy.
- rx_valid in IDLE: ignored.
- busy = (state != IDLE).
- done and error are mutually exclusive and hold until the next accepted start or reset.
- sysreset mid-load: immediate return to IDLE; all outputs 0; a RAM write in flight is cut (ram_wren deasserts asynchronously).

Decomposition:
- Shared package: the state enum (IDLE, LO, HI, WRITE) and a LOADER_STATUS bit-position constant set (busy=0, done=1, error=2), so the visor status register maps directly onto these bits.
- One natural sub-module: loader_timeout, a loadable down-counter with clear and expire outputs.
- Everything else is inline.

Test Plan:
- start base=0x010, count=2; bytes 34,12,78,56 -> writes 0x1234@0x010 then 0x5678@0x011; done=1; words_written=2; checksum=0x68AC.
- base=0x3FF, count=2, bytes 01,00,02,00 -> writes at 0x3FF then 0x000 (wrap); checksum=0x0003.
- count=0 -> done=1 one cycle after start; no ram_wren.
- TIMEOUT_CYCLES=16, count=1, send one byte then idle -> error=1 sixteen cycles after that byte; busy=0; no write.
- Abort after one of two words -> busy=0; done=0; error=0; words_written=1. A following start with count=1 succeeds.
- Two rx_valid strobes on back-to-back cycles, where the second lands in WRITE -> error=1; exactly one ram_wren pulse.
